// File: rtl/mult_eval_pkg.sv
// Shared types and accumulator width helpers
// for the approximate-multiplier error evaluator.
package mult_eval_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   function automatic int sum_ed_w(input int w);
      return 4 * w;
   endfunction

   function automatic int sum_err_w(input int w);
      return 4 * w + 1;
   endfunction

   function automatic int cnt_w(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/mult_err_accum.sv
// Second pipeline stage: error of one pair folded
// into the four running metrics.
module mult_err_accum
   import mult_eval_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    v1,
   input  logic [2*W-1:0]          approx,
   input  logic [2*W-1:0]          exact,
   output logic [sum_ed_w(W)-1:0]  sum_ed,
   output logic [sum_err_w(W)-1:0] sum_err,
   output logic [2*W-1:0]          max_ed,
   output logic [cnt_w(W)-1:0]     err_cnt
);

   localparam int PW = 2 * W;
   localparam int EW = sum_ed_w(W);
   localparam int SW = sum_err_w(W);
   localparam int CW = cnt_w(W);

   logic signed [PW:0]   e;
   logic [PW-1:0]        ed;
   logic [EW-1:0]        sum_ed_q;
   logic signed [SW-1:0] sum_err_q;
   logic [PW-1:0]        max_ed_q;
   logic [CW-1:0]        err_cnt_q;

   // Signed error and its magnitude; |e| always fits in PW bits
   always_comb begin
      e  = $signed({1'b0, approx}) - $signed({1'b0, exact});
      ed = e[PW] ? PW'(-e) : PW'(e);
   end

   // Metric registers: cleared at sweep start, updated per valid pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ed_q  <= '0;
         sum_err_q <= '0;
         max_ed_q  <= '0;
         err_cnt_q <= '0;
      end else if (clr) begin
         sum_ed_q  <= '0;
         sum_err_q <= '0;
         max_ed_q  <= '0;
         err_cnt_q <= '0;
      end else if (v1) begin
         sum_ed_q  <= sum_ed_q + EW'(ed);
         sum_err_q <= sum_err_q + SW'(e);
         if (ed > max_ed_q) max_ed_q <= ed;
         err_cnt_q <= err_cnt_q + CW'(|e);
      end
   end

   assign sum_ed  = sum_ed_q;
   assign sum_err = sum_err_q;
   assign max_ed  = max_ed_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: rtl/mult_error_evaluator.sv
// Sweeps all operand pairs through a candidate
// multiplier and accumulates its error metrics.
module mult_error_evaluator
   import mult_eval_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   output logic [W-1:0]            op_a,
   output logic [W-1:0]            op_b,
   input  logic [2*W-1:0]          approx_p,
   output logic                    busy,
   output logic                    done,
   output logic [sum_ed_w(W)-1:0]  sum_ed,
   output logic [sum_err_w(W)-1:0] sum_err,
   output logic [2*W-1:0]          max_ed,
   output logic [cnt_w(W)-1:0]     err_cnt
);

   localparam int PW = 2 * W;
   localparam longint NPAIRS = 64'd1 << PW;
   localparam logic [PW-1:0] LAST = PW'(NPAIRS - 1);

   state_e        state_q;
   logic [PW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;
   logic [PW-1:0] ap_q;
   logic [PW-1:0] ex_q;
   logic          v1_q;
   logic          clr;

   // A sweep begins on an accepted start; abort overrides it
   assign clr = start && !abort &&
                (state_q == S_IDLE || state_q == S_DONE);

   // Sequencer: pair counter, state and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (abort) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q + PW'(1);
               if (cnt_q == LAST) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               state_q <= S_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         endcase
      end
   end

   // First stage: capture candidate and exact product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         ap_q <= '0;
         ex_q <= '0;
      end else begin
         v1_q <= (state_q == S_RUN) && !abort;
         ap_q <= approx_p;
         ex_q <= PW'(op_a) * PW'(op_b);
      end
   end

   mult_err_accum #(.W(W)) u_accum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .v1      (v1_q && !abort),
      .approx  (ap_q),
      .exact   (ex_q),
      .sum_ed  (sum_ed),
      .sum_err (sum_err),
      .max_ed  (max_ed),
      .err_cnt (err_cnt)
   );

   assign op_a = cnt_q[W-1:0];
   assign op_b = cnt_q[PW-1:W];
   assign busy = busy_q;
   assign done = done_q;

endmodule
